// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/valid memory port between instruction fetch and LSU.
// An in-order ID FIFO routes each response back to the requester that issued it.
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_gnt,
    output logic [31:0] instr_rdata,
    output logic        instr_valid,
    output logic        instr_err,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_be,
    output logic        data_gnt,
    output logic [31:0] data_rdata,
    output logic        data_valid,
    output logic        data_error,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    input  logic        mem_err,

    output logic        protocol_err
);
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_INSTR = 2'd1,
        SEL_DATA  = 2'd2
    } sel_e;

    sel_e                sel;
    sel_e                lock_sel_reg;
    logic                lock_reg;
    logic [STARVE_W-1:0] starve_reg;
    logic                protocol_err_reg;

    logic                id_mem_reg [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;

    logic fifo_full;
    logic fifo_empty;
    logic grant;
    logic push;
    logic pop;
    logic head_id;

    assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_reg == '0);
    assign head_id    = id_mem_reg[rd_ptr_reg];

    // A waiting request keeps its slot; otherwise data wins unless instr has been starved.
    always_comb begin
        sel = SEL_NONE;
        if (lock_reg) begin
            sel = lock_sel_reg;
        end else if (instr_req && ((starve_reg == STARVE_W'(STARVE_LIMIT)) || !data_req)) begin
            sel = SEL_INSTR;
        end else if (data_req) begin
            sel = SEL_DATA;
        end
    end

    assign mem_req = (instr_req | data_req) & ~fifo_full;

    always_comb begin
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        case (sel)
            SEL_INSTR: begin
                mem_addr = instr_addr;
                mem_be   = 4'hF;
            end
            SEL_DATA: begin
                mem_wr    = data_wr;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
                mem_be    = data_be;
            end
            default: ;
        endcase
    end

    assign grant     = mem_req & mem_gnt;
    assign instr_gnt = grant & (sel == SEL_INSTR);
    assign data_gnt  = grant & (sel == SEL_DATA);
    assign push      = grant;
    assign pop       = mem_valid & ~fifo_empty;

    // Responses are routed straight through; the head ID picks the destination.
    assign instr_valid  = pop & ~head_id;
    assign instr_err    = pop & ~head_id & mem_err;
    assign data_valid   = pop & head_id;
    assign data_error   = pop & head_id & mem_err;
    assign instr_rdata  = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign protocol_err = protocol_err_reg;

    // ID storage is only read while the FIFO is non-empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem_reg[wr_ptr_reg] <= (sel == SEL_DATA);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_reg         <= 1'b0;
            lock_sel_reg     <= SEL_NONE;
            starve_reg       <= '0;
            protocol_err_reg <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
        end else begin
            if (mem_req && !mem_gnt) begin
                lock_reg     <= 1'b1;
                lock_sel_reg <= sel;
            end else if (grant) begin
                lock_reg <= 1'b0;
            end

            if (instr_gnt) begin
                starve_reg <= '0;
            end else if (data_gnt && instr_req && (starve_reg != STARVE_W'(STARVE_LIMIT))) begin
                starve_reg <= starve_reg + STARVE_W'(1);
            end

            if (mem_valid && fifo_empty) begin
                protocol_err_reg <= 1'b1;
            end

            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized phase with a
// behavioural memory, per-requester expectation queues and an independent monitor.
module tb_mem_port_arbiter;
    localparam int MAX_OUT = 2;
    localparam int LIMIT   = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_req, instr_gnt, instr_valid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_wr, data_gnt, data_valid, data_error;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        mem_req, mem_wr, mem_gnt, mem_valid, mem_err, protocol_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
        .instr_rdata(instr_rdata), .instr_valid(instr_valid), .instr_err(instr_err),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_be(data_be), .data_gnt(data_gnt),
        .data_rdata(data_rdata), .data_valid(data_valid), .data_error(data_error),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .mem_err(mem_err), .protocol_err(protocol_err)
    );

    typedef struct packed { logic [31:0] rdata; logic chk; logic err; } exp_t;
    typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;

    exp_t        instr_exp_q[$];
    exp_t        data_exp_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] ref_mem [0:255];
    logic [31:0] mdl_mem [0:255];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          auto_mem = 1'b0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: rdata is what the memory holds when the request is issued; bit 12 marks a faulting address.
    task automatic issue_instr();
        logic [31:0] a;
        exp_t        e;
        a = ($urandom_range(0, 7) == 0 ? 32'h1000 : 32'h0) | ($urandom_range(0, 127) << 2);
        instr_req  = 1'b1;
        instr_addr = a;
        e.err   = a[12];
        e.chk   = !a[12];
        e.rdata = ref_mem[a[9:2]];
        instr_exp_q.push_back(e);
    endtask

    task automatic issue_data();
        logic [31:0] a;
        exp_t        e;
        a = ($urandom_range(0, 7) == 0 ? 32'h1000 : 32'h0) | 32'h200 | ($urandom_range(0, 127) << 2);
        data_req   = 1'b1;
        data_addr  = a;
        data_wr    = 1'($urandom_range(0, 1));
        data_be    = 4'($urandom_range(1, 15));
        data_wdata = $urandom;
        e.err   = a[12];
        e.chk   = !data_wr && !a[12];
        e.rdata = ref_mem[a[9:2]];
        if (data_wr && !a[12]) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be[b]) ref_mem[a[9:2]][8*b +: 8] = data_wdata[8*b +: 8];
            end
        end
        data_exp_q.push_back(e);
    endtask

    // Behavioural single-port memory: random grant, in-order responses after >=1 cycle.
    task automatic mem_model();
        rsp_t r;
        forever begin
            @(negedge clk);
            if (auto_mem && reset_n && mem_req && mem_gnt) begin
                r.err = mem_addr[12];
                r.rdata = $urandom;
                if (!mem_addr[12]) begin
                    if (mem_wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mem_be[b]) mdl_mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                        end
                    end else begin
                        r.rdata = mdl_mem[mem_addr[9:2]];
                    end
                end
                rsp_q.push_back(r);
            end
            @(posedge clk);
            #1;
            if (auto_mem) begin
                mem_gnt = ($urandom_range(0, 2) != 0);
                if (rsp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                    r = rsp_q.pop_front();
                    mem_valid = 1'b1;
                    mem_rdata = r.rdata;
                    mem_err   = r.err;
                end else begin
                    mem_valid = 1'b0;
                    mem_rdata = $urandom;
                    mem_err   = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    task automatic monitor();
        exp_t        e;
        logic        prev_wait = 1'b0;
        logic        prev_wr = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [31:0] prev_wdata = '0;
        logic [3:0]  prev_be = '0;
        int          streak = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_wait = 1'b0;
                streak = 0;
                instr_exp_q.delete();
                data_exp_q.delete();
            end else begin
                if (instr_valid) begin
                    if (instr_exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL instr_valid_unexpected: got valid, required no fetch response (t=%0t)", $time);
                    end else begin
                        e = instr_exp_q.pop_front();
                        if (e.chk) check32("instr_rdata", instr_rdata, e.rdata);
                        check_bit("instr_err", instr_err, e.err);
                    end
                end
                if (data_valid) begin
                    if (data_exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL data_valid_unexpected: got valid, required no LSU response (t=%0t)", $time);
                    end else begin
                        e = data_exp_q.pop_front();
                        if (e.chk) check32("data_rdata", data_rdata, e.rdata);
                        check_bit("data_error", data_error, e.err);
                    end
                end
                if (mem_err && !mem_valid) check_bit("err_without_valid", instr_err | data_error, 1'b0);
                if (instr_gnt || data_gnt) check_bit("gnt_exclusive", instr_gnt & data_gnt, 1'b0);
                if (prev_wait) begin
                    check_bit("lock_req_held", mem_req, 1'b1);
                    check32("lock_addr", mem_addr, prev_addr);
                    check32("lock_wdata", mem_wdata, prev_wdata);
                    check32("lock_be", 32'(mem_be), 32'(prev_be));
                    check_bit("lock_wr", mem_wr, prev_wr);
                end
                if (data_gnt && instr_req) begin
                    check_bit("starve_limit", streak < LIMIT, 1'b1);
                    streak++;
                end
                if (instr_gnt) streak = 0;
                prev_wait  = mem_req && !mem_gnt;
                prev_addr  = mem_addr;
                prev_wdata = mem_wdata;
                prev_be    = mem_be;
                prev_wr    = mem_wr;
            end
        end
    endtask

    initial begin
        string seq;
        bit    instr_busy;
        bit    data_busy;

        reset_n = 1'b0;
        instr_req = 1'b0; instr_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
        mem_gnt = 1'b0; mem_valid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h1357_0000 ^ (i * 32'h0009_E377);
            mdl_mem[i] = 32'h1357_0000 ^ (i * 32'h0009_E377);
        end
        fork
            monitor();
            mem_model();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check_bit("rst_mem_req", mem_req, 1'b0);
        check_bit("rst_instr_gnt", instr_gnt, 1'b0);
        check_bit("rst_data_gnt", data_gnt, 1'b0);
        check_bit("rst_instr_valid", instr_valid, 1'b0);
        check_bit("rst_data_valid", data_valid, 1'b0);
        check_bit("rst_protocol_err", protocol_err, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_be", 32'(mem_be), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single fetch
        instr_req = 1'b1; instr_addr = 32'h100; mem_gnt = 1'b1;
        instr_exp_q.push_back('{32'h0000_0013, 1'b1, 1'b0});
        @(negedge clk);
        check_bit("fetch_gnt", instr_gnt, 1'b1);
        check32("fetch_addr", mem_addr, 32'h100);
        check32("fetch_be", 32'(mem_be), 32'hF);
        check_bit("fetch_wr", mem_wr, 1'b0);
        @(posedge clk); #1;
        instr_req = 1'b0; mem_gnt = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        check_bit("fetch_valid", instr_valid, 1'b1);
        check32("fetch_rdata", instr_rdata, 32'h0000_0013);
        check_bit("fetch_no_data_valid", data_valid, 1'b0);
        @(posedge clk); #1;
        mem_valid = 1'b0;

        // Both requesters continuously active: starvation guard
        seq = "DDDDIDDDDI";
        instr_req = 1'b1; instr_addr = 32'h40;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200; data_be = 4'hF;
        mem_gnt = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            mem_valid = (k > 0);
            mem_rdata = 32'hA000 + k;
            if (k == 10) begin
                instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
            end
            @(negedge clk);
            if (k < 10) begin
                check_bit("starve_seq_instr", instr_gnt, seq[k] == "I");
                check_bit("starve_seq_data", data_gnt, seq[k] == "D");
                if (instr_gnt) instr_exp_q.push_back('{32'hA000 + k + 1, 1'b1, 1'b0});
                if (data_gnt) data_exp_q.push_back('{32'hA000 + k + 1, 1'b1, 1'b0});
            end
            @(posedge clk); #1;
        end
        mem_valid = 1'b0;

        // Data write waits for grant while instr arrives; the memory faults it
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h200; data_be = 4'h3; data_wdata = 32'hDEAD_BEEF;
        data_exp_q.push_back('{32'h0, 1'b0, 1'b1});
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                instr_req = 1'b1; instr_addr = 32'h80;
                instr_exp_q.push_back('{32'h0000_0297, 1'b1, 1'b0});
            end
            mem_gnt = (k == 3);
            @(negedge clk);
            check32("wait_addr", mem_addr, 32'h200);
            check32("wait_be", 32'(mem_be), 32'h3);
            check_bit("wait_wr", mem_wr, 1'b1);
            check_bit("wait_data_gnt", data_gnt, k == 3);
            check_bit("wait_instr_gnt", instr_gnt, 1'b0);
            @(posedge clk); #1;
        end

        // Instr waits; data arriving must not steal the slot
        data_req = 1'b0; data_wr = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        check32("instr_sel_addr", mem_addr, 32'h80);
        @(posedge clk); #1;
        data_req = 1'b1; data_addr = 32'h204; data_be = 4'hF;
        data_exp_q.push_back('{32'h1234_5678, 1'b1, 1'b0});
        @(negedge clk);
        check32("lock_hold_addr", mem_addr, 32'h80);
        check_bit("lock_hold_wr", mem_wr, 1'b0);
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk);
        check_bit("lock_instr_gnt", instr_gnt, 1'b1);
        check_bit("lock_data_gnt", data_gnt, 1'b0);
        @(posedge clk); #1;
        instr_req = 1'b0;
        @(negedge clk);
        check_bit("full_mem_req", mem_req, 1'b0);
        check_bit("full_data_gnt", data_gnt, 1'b0);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_err = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check_bit("err_data_valid", data_valid, 1'b1);
        check_bit("err_data_error", data_error, 1'b1);
        check_bit("err_instr_valid", instr_valid, 1'b0);
        check_bit("err_instr_err", instr_err, 1'b0);
        check_bit("pop_cycle_mem_req", mem_req, 1'b0);
        @(posedge clk); #1;
        mem_err = 1'b0; mem_rdata = 32'h0000_0297; mem_gnt = 1'b0;
        @(negedge clk);
        check_bit("reassert_mem_req", mem_req, 1'b1);
        check_bit("second_instr_valid", instr_valid, 1'b1);
        check_bit("second_data_valid", data_valid, 1'b0);
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        check_bit("read_data_gnt", data_gnt, 1'b1);
        @(posedge clk); #1;
        data_req = 1'b0; mem_gnt = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        check_bit("read_data_valid", data_valid, 1'b1);
        @(posedge clk); #1;
        mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        check_bit("stray_instr_valid", instr_valid, 1'b0);
        check_bit("stray_data_valid", data_valid, 1'b0);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_bit("protocol_err_sticky", protocol_err, 1'b1);
        end

        // Asynchronous reset with two transactions outstanding
        @(posedge clk); #1;
        instr_req = 1'b1; instr_addr = 32'h100; mem_gnt = 1'b1;
        @(negedge clk);
        check_bit("pre_rst_instr_gnt", instr_gnt, 1'b1);
        @(posedge clk); #1;
        instr_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h208;
        @(negedge clk);
        check_bit("pre_rst_data_gnt", data_gnt, 1'b1);
        @(posedge clk); #1;
        data_addr = 32'h20C; mem_gnt = 1'b0;
        @(negedge clk);
        check_bit("pre_rst_full", mem_req, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_bit("async_rst_fifo_empty", mem_req, 1'b1);
        check_bit("async_rst_protocol_err", protocol_err, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_rdata = 32'h0000_0BAD;
        @(negedge clk);
        check_bit("late_rsp_instr_valid", instr_valid, 1'b0);
        check_bit("late_rsp_data_valid", data_valid, 1'b0);
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_gnt = 1'b1;
        data_exp_q.push_back('{32'h55AA_55AA, 1'b1, 1'b0});
        @(negedge clk);
        check_bit("late_rsp_protocol_err", protocol_err, 1'b1);
        check_bit("post_rst_data_gnt", data_gnt, 1'b1);
        @(posedge clk); #1;
        data_req = 1'b0; mem_gnt = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h55AA_55AA;
        @(negedge clk);
        check_bit("post_rst_data_valid", data_valid, 1'b1);
        @(posedge clk); #1;
        mem_valid = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        check_bit("rst_clears_protocol_err", protocol_err, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1; instr_req = 1'b1; instr_addr = 32'h104; mem_gnt = 1'b1;
        instr_exp_q.push_back('{32'h0010_0093, 1'b1, 1'b0});
        @(negedge clk);
        check_bit("post_rst_fetch_gnt", instr_gnt, 1'b1);
        @(posedge clk); #1;
        instr_req = 1'b0; mem_gnt = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h0010_0093;
        @(negedge clk);
        check_bit("post_rst_fetch_valid", instr_valid, 1'b1);
        check32("post_rst_fetch_rdata", instr_rdata, 32'h0010_0093);
        check_bit("post_rst_protocol_err", protocol_err, 1'b0);
        @(posedge clk); #1;
        mem_valid = 1'b0;

        // Randomized traffic against the behavioural memory
        auto_mem = 1'b1;
        instr_busy = 1'b0;
        data_busy = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (instr_gnt) instr_busy = 1'b0;
            if (data_gnt) data_busy = 1'b0;
            @(posedge clk); #1;
            if (!instr_busy) begin
                if (c < 3600 && $urandom_range(0, 2) == 0) begin
                    issue_instr();
                    instr_busy = 1'b1;
                end else begin
                    instr_req = 1'b0;
                end
            end
            if (!data_busy) begin
                if (c < 3600 && $urandom_range(0, 1) == 0) begin
                    issue_data();
                    data_busy = 1'b1;
                end else begin
                    data_req = 1'b0;
                end
            end
        end
        check_bit("drain_requests_done", instr_busy | data_busy, 1'b0);
        check32("drain_instr_pending", 32'(instr_exp_q.size()), 32'h0);
        check32("drain_data_pending", 32'(data_exp_q.size()), 32'h0);
        auto_mem = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview: Shares one single-port memory (tb_memory-style req/gnt/valid protocol) between the core instruction-fetch and data (LSU) interfaces. It arbitrates requests, holds the selection while a request waits for grant, and tracks in-flight transactions in an in-order ID FIFO so each response returns to its issuer. It sits between riscv_core and a unified memory model, and enables single-memory bench configurations.

Parameters:
MAX_OUTSTANDING, 2, depth of the response-routing ID FIFO (1..4); maximum granted-but-unanswered transactions
STARVE_LIMIT, 4, consecutive data grants while instr_req waits before instr is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr_req  in  1  fetch request; held until instr_gnt
instr_addr  in  32  fetch address
instr_gnt  out  1  fetch accepted this cycle
instr_rdata  out  32  fetch read data
instr_valid  out  1  fetch response valid
instr_err  out  1  fetch response error (with instr_valid)
data_req  in  1  LSU request; held until data_gnt
data_wr  in  1  1=write, 0=read
data_addr  in  32  LSU address
data_wdata  in  32  write data
data_be  in  4  byte enables
data_gnt  out  1  LSU request accepted
data_rdata  out  32  LSU read data
data_valid  out  1  LSU response valid
data_error  out  1  LSU response error (with data_valid)
mem_req  out  1  request to memory
mem_wr  out  1  write strobe
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables
mem_gnt  in  1  memory accepted request
mem_rdata  in  32  memory read data
mem_valid  in  1  memory response valid
mem_err  in  1  memory response error
protocol_err  out  1  sticky: mem_valid received with no transaction outstanding

Behaviour:
- Reset: ID FIFO empty, starve counter 0, lock clear, protocol_err 0. All outputs 0 while reset_n=0 and requesters idle.
- Selection, combinational: lock set -> locked requester; else instr if instr_req and (starve==STARVE_LIMIT or !data_req); else data if data_req; else none.
- mem_req = (instr_req|data_req) & !fifo_full. Address/control muxed from selected port. Instr fetch drives mem_wr=0, mem_be=4'hF, mem_wdata=0.
- Grants are combinational passthrough: instr_gnt = mem_req & mem_gnt & sel==instr; likewise data_gnt. Both are never 1 in the same cycle.
- Lock: if mem_req & !mem_gnt, register the selection. Next cycle the selection stays there, and the mem_* outputs stay stable, even if the other requester rises. Lock clears on the grant.
- Starve counter increments (saturating at STARVE_LIMIT) on each data grant while instr_req=1. It clears on an instr grant.
- ID FIFO: push the requester ID (0=instr, 1=data) on mem_req & mem_gnt; pop on mem_valid. Push and pop in the same cycle leave the count unchanged. When full, there is no push because mem_req is gated; a pop is still allowed.
- Response routing: the head ID selects the target. instr_valid = mem_valid & !empty & head==0; instr_err = mem_err under the same condition. Data side uses head==1. mem_rdata is fanned out to both rdata ports; meaningful only with the matching valid.
- Response latency: zero added cycles. Responses return strictly in grant order, and the memory must respond in order.
- mem_valid with FIFO empty: the response is dropped, no valid is routed, and protocol_err sets. protocol_err holds until reset.
- mem_err without mem_valid is ignored.
- Reset mid-transaction asynchronously clears the FIFO, lock, counter and flag. Late responses after reset trigger protocol_err.

Test Plan:
- Instr only, addr 0x100, mem_gnt=1, mem_valid next cycle with rdata 0x00000013 -> instr_gnt=1 at t0; instr_valid=1 with instr_rdata=0x13 at t1; data_valid stays 0.
- instr_req and data_req held high continuously, mem_gnt=1, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Data write 0x200/be 4'h3 with mem_gnt low 3 cycles, instr_req rising in cycle 1 -> mem_addr=0x200, mem_be=4'h3, mem_wr=1 stable all 4 cycles; data_gnt only in cycle 4.
- MAX_OUTSTANDING=2: grant instr then data with no mem_valid -> mem_req=0 while requests pending. Two mem_valid pulses -> instr_valid then data_valid, in that order; mem_req reasserts the cycle after the first pop.
- mem_valid+mem_err with data at head -> data_valid=1, data_error=1, instr_err=0. Later mem_valid with FIFO empty -> protocol_err=1 and held.
- Assert reset_n=0 with 2 outstanding -> FIFO empty and protocol_err=0 immediately (asynchronous). After release, a single fetch works normally.
